// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ clients.
// Frames are timed internally because the transmitter reports no completion.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 12,
    parameter int GAP_CYCLES   = 1,
    parameter int ID_W         = 2
) (
    input  logic                 clk_1,
    input  logic                 rst_n_1,
    input  logic [NUM_REQ-1:0]   req_1,
    input  logic [8*NUM_REQ-1:0] data_1,
    output logic [NUM_REQ-1:0]   ack_1,
    output logic [ID_W-1:0]      grant_id_1,
    output logic [7:0]           tx_din_1,
    output logic                 tx_trigger_1,
    output logic                 busy_1
);

    localparam int MAX_CNT = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT) + 1;
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic [7:0]          din_q, din_d;
    logic                trig_q, trig_d;

    logic                found;
    logic [ID_W-1:0]     winner;
    logic [ID_W:0]       scanIdx;

    // Scan requesters starting at the pointer, wrapping modulo NUM_REQ; first hit wins.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        scanIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scanIdx >= NUM_REQ_W) begin
                scanIdx = scanIdx - NUM_REQ_W;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && scanIdx == (ID_W+1)'(j) && req_1[j]) begin
                    found  = 1'b1;
                    winner = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        trig_d  = 1'b0;
        gid_d   = gid_q;
        din_d   = din_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (winner == ID_W'(i)) begin
                            din_d    = data_1[8*i +: 8];
                            ack_d[i] = 1'b1;
                        end
                    end
                    trig_d  = 1'b1;
                    gid_d   = winner;
                    ptr_d   = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
                    cnt_d   = CW'(FRAME_CYCLES-1);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = CW'(GAP_CYCLES-1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1 or negedge rst_n_1) begin
        if (!rst_n_1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            trig_q  <= 1'b0;
            gid_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            trig_q  <= trig_d;
            gid_q   <= gid_d;
            din_q   <= din_d;
        end
    end

    assign ack_1        = ack_q;
    assign tx_trigger_1 = trig_q;
    assign grant_id_1   = gid_q;
    assign tx_din_1     = din_q;
    assign busy_1       = (state_q != IDLE);

endmodule
